mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the pipeline IF stage (read-only) and the MEM stage (read/write).
//  Sequences each access over a fixed memory latency, returns the data, and raises per-stage stall signals
//  that freeze the pipeline while a request is pending. Sits between the CPU core and the memory, inside the top-level computer.
// PARAMETERS
//  DW          32  data width (bits)
//  AW          32  byte address width
//  LAT         2   memory read latency in cycles (>=1); rdata valid LAT edges after mem_en first sampled
//  STARVE_MAX  4   max consecutive DM grants while if_req is pending before IF is forced
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  if_req     in   1      IF read request; held until if_ack or if_flush
//  if_addr    in   AW     IF address, stable while if_req
//  if_flush   in   1      pulse: discard pending/in-flight IF access (taken branch)
//  if_ack     out  1      1-cycle pulse: if_rdata valid
//  if_rdata   out  DW     fetched word (registered)
//  if_stall   out  1      if_req & ~if_ack (combinational)
//  dm_req     in   1      MEM-stage request; held until dm_ack
//  dm_we      in   1      1=write, 0=read
//  dm_be      in   DW/8   byte enables for writes
//  dm_addr    in   AW     data address
//  dm_wdata   in   DW     write data
//  dm_ack     out  1      1-cycle pulse: access complete
//  dm_rdata   out  DW     read data (registered; updated on reads only)
//  dm_stall   out  1      dm_req & ~dm_ack (combinational)
//  mem_en     out  1      memory access active
//  mem_we     out  1      memory write enable
//  mem_be     out  DW/8   memory byte enables
//  mem_addr   out  AW     memory address
//  mem_wdata  out  DW     memory write data
//  mem_rdata  in   DW     memory read data
// BEHAVIOUR
//  Reset: state IDLE, all registered outputs 0 (acks, rdata, mem_*), wait counter and streak counter 0; in-flight access dropped.
//  FSM IDLE -> BUSY -> RESP -> IDLE.
//   IDLE: if any req, pick a grant. At the edge: register mem_* from the winner, set cnt=LAT, go to BUSY. Otherwise mem_en=0.
//   BUSY: mem_* held constant. cnt decrements each edge. At the edge where cnt==1: capture mem_rdata
//     (reads only; writes leave rdata unchanged), clear mem_en/mem_we, go to RESP.
//   RESP: pulse ack of the granted port for one cycle, then go to IDLE.
//   Timing: req seen in IDLE cycle 0 -> ack in cycle LAT+1; one access every LAT+2 cycles.
//  Arbitration: DM has priority over IF.
//   If if_req && streak==STARVE_MAX, grant IF and clear streak.
//   DM grant with if_req high: streak++. IF grant, or if_req low at arbitration: streak=0.
//  IF access: mem_we=0, mem_be all 1s.
//  if_flush: in IDLE, the IF request is ignored that cycle.
//   With IF granted in BUSY/RESP: the memory access completes, if_ack is suppressed, if_rdata is not updated, FSM returns to IDLE normally.
//   Flush with DM granted: no effect.
//  Simultaneous if_flush and if_ack cycle: ack is suppressed.
//  Requester dropping req mid-access (other than flush) is illegal; the access completes and the ack is still issued.
//  Async rst mid-BUSY: outputs go to 0 immediately; the memory sees mem_en fall.
//  dm_addr/if_addr are passed unmodified; alignment is the core's responsibility.
// STRUCTURE
//  Package mem_arb_pkg:
//   - state enum {IDLE, BUSY, RESP}
//   - grant encoding {GNT_IF, GNT_DM}
//   - LAT counter width function clog2(LAT+1)
//  One sub-module: arb_pick (combinational; inputs if_req, dm_req, streak, if_flush -> grant, valid). All else inline.
// TESTING (LAT=2, STARVE_MAX=4)
//  1. if_req, addr 0x10, mem returns 0x00500093 -> mem_en high 2 cycles, mem_addr=0x10; if_ack in cycle 3 with if_rdata=0x00500093; if_stall high cycles 0-2.
//  2. if_req & dm_req (read) together in cycle 0 -> dm_ack cycle 3, if_ack cycle 7; mem_addr shows dm_addr first.
//  3. DM write, be=4'b0011, wdata=0xDEADBEEF -> mem_we=1, mem_be=0011 for 2 cycles; dm_ack cycle 3; dm_rdata unchanged.
//  4. dm_req and if_req held continuously -> grants DM,DM,DM,DM,IF,DM...; if_ack cycle 19.
//  5. IF granted, if_flush pulsed in the first BUSY cycle -> no if_ack, if_rdata unchanged, IDLE by cycle 4, next IF req served normally.
//  6. rst asserted mid-BUSY (async, between edges) -> mem_en, acks, rdata = 0 immediately; after release, a new DM read acks in cycle 3.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, grant
// encoding and the width helper used for the latency and streak counters.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_t;

  // Bits needed to hold the values 0..max inclusive.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Grant selection between the fetch port and the data port. The data port
// wins by default. After STARVE_MAX consecutive data grants with fetch
// waiting, fetch is forced through. A fetch flushed this cycle is treated
// as absent.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int SW         = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic          if_req,
  input  logic          dm_req,
  input  logic [SW-1:0] streak,
  input  logic          if_flush,
  output grant_t        grant,
  output logic          valid
);

  logic if_live;

  // Priority pick: forced fetch, then data, then plain fetch.
  always_comb begin
    if_live = if_req & ~if_flush;
    grant   = GNT_DM;
    valid   = 1'b0;
    if (if_live && (streak == SW'(STARVE_MAX))) begin
      grant = GNT_IF;
      valid = 1'b1;
    end else if (dm_req) begin
      grant = GNT_DM;
      valid = 1'b1;
    end else if (if_live) begin
      grant = GNT_IF;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch stage (read-only) and the
// data stage (read/write). Each access runs IDLE -> BUSY (LAT cycles) ->
// RESP (ack pulse) -> IDLE, so one access completes every LAT+2 cycles.
//
// Handshake: a requester raises *_req and holds it (with address/data
// stable) until its *_ack pulse. The ack is a single-cycle pulse in the
// cycle after the memory data is captured. *_stall is req & ~ack, so the
// pipeline stays frozen exactly until the ack cycle. The fetch side may
// also abandon its request with an if_flush pulse, which masks any ack
// still owed to it.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_flush,
  output logic            if_ack,
  output logic [DW-1:0]   if_rdata,
  output logic            if_stall,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [DW/8-1:0] dm_be,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  output logic            dm_ack,
  output logic [DW-1:0]   dm_rdata,
  output logic            dm_stall,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output arb_state_t      dbg_state
);

  localparam int BW = DW / 8;
  localparam int CW = cnt_width(LAT);
  localparam int SW = cnt_width(STARVE_MAX);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  grant_t        gnt_q, gnt_d;
  logic          flushed_q, flushed_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [BW-1:0] mem_be_q, mem_be_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          dm_ack_q, dm_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;

  grant_t pick_grant;
  logic   pick_valid;
  logic   if_live;

  arb_pick #(
    .SW         (SW),
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .if_req   (if_req),
    .dm_req   (dm_req),
    .streak   (streak_q),
    .if_flush (if_flush),
    .grant    (pick_grant),
    .valid    (pick_valid)
  );

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    if_live     = if_req & ~if_flush;
    state_d     = state_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    gnt_d       = gnt_q;
    flushed_d   = flushed_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    case (state_q)
      IDLE: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        // The streak only grows while fetch is actually waiting behind data.
        if (pick_valid && (pick_grant == GNT_DM) && if_live) begin
          streak_d = streak_q + SW'(1);
        end else begin
          streak_d = '0;
        end
        if (pick_valid) begin
          state_d   = BUSY;
          cnt_d     = CW'(LAT);
          gnt_d     = pick_grant;
          flushed_d = 1'b0;
          mem_en_d  = 1'b1;
          if (pick_grant == GNT_DM) begin
            mem_we_d    = dm_we;
            mem_be_d    = dm_be;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_be_d    = '1;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end
        end
      end

      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if ((gnt_q == GNT_IF) && if_flush) begin
          flushed_d = 1'b1;
        end
        if (cnt_q == CW'(1)) begin
          state_d  = RESP;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (gnt_q == GNT_DM) begin
            dm_ack_d = 1'b1;
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end
          end else if (!(flushed_q || if_flush)) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Single register bank for FSM state, counters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      streak_q    <= '0;
      gnt_q       <= GNT_IF;
      flushed_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      gnt_q       <= gnt_d;
      flushed_q   <= flushed_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  // A flush landing in the ack cycle itself can only mask the pulse; the
  // fetch data register was already loaded on the previous edge.
  assign if_ack    = if_ack_q & ~if_flush;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_stall  = if_req & ~if_ack;
  assign dm_stall  = dm_req & ~dm_ack;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dbg_state = state_q;

endmodule
